tx_varcic_interp: RTL and testbench
===================================

Name: tx_varcic_interp

Overview:
- Transmit-side counterpart of the receive decimation chain: a variable-rate I/Q CIC interpolator.
- Fetches baseband I/Q samples from an upstream sample source (FIR/FIFO) at the low rate.
- Produces interpolated I/Q at the rate set by sample_strobe, feeding the up-conversion CORDIC.
- Interpolation ratio is runtime-selectable, 2..40; gain is normalised by a rate-dependent arithmetic shift.

Parameters:
STAGES, 5, number of comb and integrator stages (differential delay fixed at 1)
IN_WIDTH, 18, signed input sample width
ACC_WIDTH, 40, signed comb/integrator width (IN_WIDTH + ceil(STAGES-1)*log2(40)) + margin)
OUT_WIDTH, 18, signed output sample width

Ports:
clock  input  1  system clock, 122.88 MHz
reset  input  1  synchronous, active-high
rate  input  6  interpolation ratio R; values <2 clamp to 2, >40 clamp to 40
sample_strobe  input  1  one-cycle tick at output sample rate (may be high every cycle)
in_req  output  1  one-cycle pulse: in_data_I/Q consumed this cycle; upstream advances
in_valid  input  1  upstream has a sample present on in_data_I/Q
in_data_I  input  IN_WIDTH  signed I sample
in_data_Q  input  IN_WIDTH  signed Q sample
out_strobe  output  1  one-cycle pulse: out_data_I/Q updated
out_data_I  output  OUT_WIDTH  signed interpolated I
out_data_Q  output  OUT_WIDTH  signed interpolated Q
underrun  output  1  sticky: a consume found in_valid low

Behaviour:
- Reset:
  - Clears the phase counter, comb delays, comb_out, integrators and the rate register.
  - Outputs: in_req=0, out_strobe=0, out_data_I/Q=0, underrun=0.
  - Clamped rate is latched into rate_r during reset.
- Phase counter:
  - Counts sample_strobe pulses 0..rate_r-1 and wraps to 0.
  - A consume occurs on a sample_strobe cycle with phase==0. in_req pulses in that same cycle.
  - in_req pulses even if in_valid is low.
- Consume:
  - If in_valid=1, the comb input is in_data. If in_valid=0, the comb input is 0 and underrun is set.
  - underrun is cleared only by reset.
- Comb cascade:
  - Evaluated combinationally on the consume cycle: c_k = c_(k-1) - d_k, where d_k is updated to c_(k-1).
  - Result is sign-extended to ACC_WIDTH and registered into comb_out.
  - Delays change only on consume.
- Zero-stuff and integrators:
  - Integrator 1 adds comb_out on the first sample_strobe after a consume and adds 0 on the other rate_r-1 strobes.
  - Integrator k adds the registered value of integrator k-1.
  - All integrators update only on sample_strobe. Wrap-around is modular two's complement and intentional.
- Output:
  - shift = (STAGES-1)*ceil(log2(rate_r)), from a combinational lookup.
  - out = integrator_STAGES >>> shift, saturated to ±(2^(OUT_WIDTH-1)-1).
  - Registered one clock after the sample_strobe cycle; out_strobe pulses in that cycle.
  - Gain is exactly 1 for power-of-two R, ≤1 otherwise.
- Latency: an impulse consumed at strobe n first appears at out_strobe after strobe n+STAGES.
- Rate change:
  - When the clamped rate differs from rate_r, the block spends one clock clearing as if reset, except underrun is kept.
  - It latches the new rate and ignores any sample_strobe in that clock.
  - The next strobe is a consume (phase 0).
- Simultaneous events:
  - reset dominates rate change, which dominates sample_strobe.
  - sample_strobe every clock is legal. Back-to-back consumes never occur, since R≥2.
- I and Q paths are identical and share all control.

Test Plan:
- sample_strobe every 4th clock, rate=8, constant in_data_I=1000, Q=-1000, in_valid=1:
  - in_req exactly once per 8 strobes.
  - After settling, out_data_I=1000 and Q=-1000 on every out_strobe.
- rate=4, single sample I=4096 then zeros:
  - Nonzero outputs span 16 consecutive strobes (STAGES*(R-1)+1).
  - They sum to 16384.
  - First nonzero output appears after strobe n+5.
- rate=3, constant I=131071:
  - Settles to 131071*81>>8 = 41471, with no saturation.
  - rate=0 and rate=63 behave as 2 and 40 respectively: in_req period is checked.
- in_valid held low for one consume at rate=8, constant input 2000:
  - underrun rises and stays high.
  - Output dips, then recovers to 2000.
  - underrun stays high until reset.
- Change rate 8→16 mid-stream:
  - One clear cycle with the strobe ignored.
  - Next strobe pulses in_req.
  - Output re-settles to the input value with in_req period 16.
- Assert reset between strobes mid-burst:
  - All outputs are 0 next cycle.
  - First strobe after release consumes.
  - Output is bit-exact to a fresh-start run.

Source files
------------

// File: rtl/tx_varcic_interp.sv
// Variable-rate I/Q CIC interpolator: combs at the input rate, zero-stuffing, integrators at the
// strobe rate, then a rate-dependent arithmetic shift and symmetric saturation to OUT_WIDTH.
module tx_varcic_interp #(
    parameter int STAGES    = 5,
    parameter int IN_WIDTH  = 18,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 18
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [5:0]                  rate,
    input  logic                        sample_strobe,
    output logic                        in_req,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data_I,
    input  logic signed [IN_WIDTH-1:0]  in_data_Q,
    output logic                        out_strobe,
    output logic signed [OUT_WIDTH-1:0] out_data_I,
    output logic signed [OUT_WIDTH-1:0] out_data_Q,
    output logic                        underrun
);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = -OUT_MAX;

    function automatic logic [2:0] ceil_log2_rate(input logic [5:0] r);
        if (r <= 6'd2)       return 3'd1;
        else if (r <= 6'd4)  return 3'd2;
        else if (r <= 6'd8)  return 3'd3;
        else if (r <= 6'd16) return 3'd4;
        else if (r <= 6'd32) return 3'd5;
        else                 return 3'd6;
    endfunction

    logic [5:0] rate_clamped;
    logic [5:0] rate_reg;
    logic [5:0] phase_reg;
    logic       pending_reg;
    logic       out_strobe_reg;
    logic       underrun_reg;
    logic       rate_change;
    logic       strobe_eff;
    logic       consume;
    logic [7:0] shift;

    always_comb begin
        rate_clamped = rate;
        if (rate < 6'd2)       rate_clamped = 6'd2;
        else if (rate > 6'd40) rate_clamped = 6'd40;
    end

    // A rate change steals its clock: any strobe arriving with it is dropped.
    assign rate_change = (rate_clamped != rate_reg);
    assign strobe_eff  = sample_strobe && !rate_change;
    assign consume     = strobe_eff && (phase_reg == 6'd0);
    assign shift       = 8'(STAGES - 1) * {5'd0, ceil_log2_rate(rate_reg)};

    assign in_req     = consume && !reset;
    assign out_strobe = out_strobe_reg;
    assign underrun   = underrun_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            rate_reg       <= rate_clamped;
            phase_reg      <= '0;
            pending_reg    <= 1'b0;
            out_strobe_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else if (rate_change) begin
            rate_reg       <= rate_clamped;
            phase_reg      <= '0;
            pending_reg    <= 1'b0;
            out_strobe_reg <= 1'b0;
        end else begin
            out_strobe_reg <= sample_strobe;
            if (sample_strobe) begin
                phase_reg   <= (phase_reg == rate_reg - 6'd1) ? 6'd0 : phase_reg + 6'd1;
                // pending marks the single non-zero slot of the zero-stuffed stream
                pending_reg <= consume;
            end
            if (consume && !in_valid)
                underrun_reg <= 1'b1;
        end
    end

    logic signed [IN_WIDTH-1:0]  din  [2];
    logic signed [OUT_WIDTH-1:0] dout [2];

    assign din[0]     = in_data_I;
    assign din[1]     = in_data_Q;
    assign out_data_I = dout[0];
    assign out_data_Q = dout[1];

    genvar gi, gs;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic signed [ACC_WIDTH-1:0] comb_delay_reg [STAGES];
            logic signed [ACC_WIDTH-1:0] comb_stage     [STAGES+1];
            logic signed [ACC_WIDTH-1:0] comb_out_reg;
            logic signed [ACC_WIDTH-1:0] integ_reg      [STAGES];
            logic signed [ACC_WIDTH-1:0] integ_last_next;
            logic signed [ACC_WIDTH-1:0] scaled;
            logic signed [OUT_WIDTH-1:0] sat_next;
            logic signed [OUT_WIDTH-1:0] out_reg;

            assign comb_stage[0] = in_valid ? ACC_WIDTH'(din[gi]) : '0;

            for (gs = 0; gs < STAGES; gs++) begin : g_comb
                assign comb_stage[gs+1] = comb_stage[gs] - comb_delay_reg[gs];
            end

            // Output is taken from the value the last integrator is about to hold,
            // so it appears one clock after the strobe.
            assign integ_last_next = integ_reg[STAGES-1] + integ_reg[STAGES-2];
            assign scaled          = integ_last_next >>> shift;
            assign dout[gi]        = out_reg;

            always_comb begin
                sat_next = scaled[OUT_WIDTH-1:0];
                if (scaled > OUT_MAX)      sat_next = OUT_MAX[OUT_WIDTH-1:0];
                else if (scaled < OUT_MIN) sat_next = OUT_MIN[OUT_WIDTH-1:0];
            end

            always_ff @(posedge clock) begin
                if (reset || rate_change) begin
                    for (int k = 0; k < STAGES; k++) begin
                        comb_delay_reg[k] <= '0;
                        integ_reg[k]      <= '0;
                    end
                    comb_out_reg <= '0;
                    out_reg      <= '0;
                end else begin
                    if (consume) begin
                        for (int k = 0; k < STAGES; k++)
                            comb_delay_reg[k] <= comb_stage[k];
                        comb_out_reg <= comb_stage[STAGES];
                    end
                    if (strobe_eff) begin
                        integ_reg[0] <= integ_reg[0] + (pending_reg ? comb_out_reg : '0);
                        for (int k = 1; k < STAGES; k++)
                            integ_reg[k] <= integ_reg[k] + integ_reg[k-1];
                        out_reg <= sat_next;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_tx_varcic_interp.sv
// Directed bench for tx_varcic_interp: a negedge monitor logs in_req/out_strobe events,
// each test task drives a scenario and compares the logs against hand-derived values.
module tb_tx_varcic_interp;
    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [5:0]         rate = 6'd8;
    logic               sample_strobe = 1'b0;
    logic               in_req;
    logic               in_valid = 1'b1;
    logic signed [17:0] in_data_I = '0;
    logic signed [17:0] in_data_Q = '0;
    logic               out_strobe;
    logic signed [17:0] out_data_I;
    logic signed [17:0] out_data_Q;
    logic               underrun;

    int checks = 0;
    int passes = 0;

    int strobe_total = 0;
    int req_log[$];
    int out_i[$];
    int out_q[$];
    int cic_coef[16];

    always #5 clock = ~clock;

    tx_varcic_interp dut (
        .clock(clock), .reset(reset), .rate(rate), .sample_strobe(sample_strobe),
        .in_req(in_req), .in_valid(in_valid), .in_data_I(in_data_I), .in_data_Q(in_data_Q),
        .out_strobe(out_strobe), .out_data_I(out_data_I), .out_data_Q(out_data_Q),
        .underrun(underrun)
    );

    // Sole writer of the event logs; tasks only read them relative to a base index.
    always @(negedge clock) begin
        if (sample_strobe) strobe_total++;
        if (in_req) req_log.push_back(strobe_total);
        if (out_strobe) begin
            out_i.push_back(int'(out_data_I));
            out_q.push_back(int'(out_data_Q));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sample_strobe = 1'b1;
            tick();
            sample_strobe = 1'b0;
            for (int j = 1; j < gap; j++) tick();
        end
        tick();
    endtask

    task automatic apply_reset(input logic [5:0] r);
        rate = r;
        sample_strobe = 1'b0;
        in_valid = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Impulse response of (1+z^-1+z^-2+z^-3)^5, the R=4 five-stage interpolator.
    task automatic build_coef();
        int p[16];
        int q[16];
        foreach (p[i]) p[i] = 0;
        p[0] = 1;
        repeat (5) begin
            foreach (q[i]) q[i] = 0;
            for (int i = 0; i < 16; i++)
                for (int t = 0; t < 4; t++)
                    if (i + t < 16) q[i+t] += p[i];
            p = q;
        end
        cic_coef = p;
    endtask

    task automatic test_reset();
        rate = 6'd8; in_data_I = 18'sd1000; in_data_Q = -18'sd1000;
        reset = 1'b1; sample_strobe = 1'b1;
        tick(); tick();
        checks++; if (in_req !== 1'b0) $display("FAIL reset_in_req: got %b expected 0", in_req); else passes++;
        checks++; if (out_strobe !== 1'b0) $display("FAIL reset_out_strobe: got %b expected 0", out_strobe); else passes++;
        checks++; if (out_data_I !== 18'sd0) $display("FAIL reset_out_I: got %0d expected 0", out_data_I); else passes++;
        checks++; if (out_data_Q !== 18'sd0) $display("FAIL reset_out_Q: got %0d expected 0", out_data_Q); else passes++;
        checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b expected 0", underrun); else passes++;
        sample_strobe = 1'b0;
        reset = 1'b0;
        $display("test_reset done: %0d/%0d", passes, checks);
    endtask

    task automatic test_constant_r8();
        int r0, o0, s0;
        apply_reset(6'd8);
        in_data_I = 18'sd1000; in_data_Q = -18'sd1000;
        r0 = req_log.size(); o0 = out_i.size(); s0 = strobe_total;
        strobes(80, 4);
        checks++; if (req_log.size() - r0 != 10) $display("FAIL r8_req_count: got %0d expected 10", req_log.size() - r0); else passes++;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (req_log[r0+k] - s0 !== 8*k + 1) $display("FAIL r8_req_pos[%0d]: got %0d expected %0d", k, req_log[r0+k] - s0, 8*k + 1);
            else passes++;
        end
        checks++; if (out_i.size() - o0 != 80) $display("FAIL r8_out_count: got %0d expected 80", out_i.size() - o0); else passes++;
        for (int j = 48; j < 80; j++) begin
            checks++; if (out_i[o0+j] !== 1000) $display("FAIL r8_out_I[%0d]: got %0d expected 1000", j, out_i[o0+j]); else passes++;
            checks++; if (out_q[o0+j] !== -1000) $display("FAIL r8_out_Q[%0d]: got %0d expected -1000", j, out_q[o0+j]); else passes++;
        end
        $display("test_constant_r8 done: %0d/%0d", passes, checks);
    endtask

    task automatic impulse_r4(input string tag, input int gap);
        int r0, o0, s0, expv, sum_i;
        r0 = req_log.size(); o0 = out_i.size(); s0 = strobe_total;
        in_data_I = 18'sd4096; in_data_Q = -18'sd4096;
        strobes(1, gap);
        in_data_I = 18'sd0; in_data_Q = 18'sd0;
        strobes(29, gap);
        checks++; if (req_log[r0] - s0 !== 1) $display("FAIL %s_first_req: got %0d expected 1", tag, req_log[r0] - s0); else passes++;
        checks++; if (out_i.size() - o0 != 30) $display("FAIL %s_out_count: got %0d expected 30", tag, out_i.size() - o0); else passes++;
        sum_i = 0;
        for (int j = 0; j < 30; j++) begin
            expv = (j >= 5 && j <= 20) ? 16 * cic_coef[j-5] : 0;
            sum_i += out_i[o0+j];
            checks++; if (out_i[o0+j] !== expv) $display("FAIL %s_I[%0d]: got %0d expected %0d", tag, j, out_i[o0+j], expv); else passes++;
            checks++; if (out_q[o0+j] !== -expv) $display("FAIL %s_Q[%0d]: got %0d expected %0d", tag, j, out_q[o0+j], -expv); else passes++;
        end
        checks++; if (sum_i !== 16384) $display("FAIL %s_sum: got %0d expected 16384", tag, sum_i); else passes++;
    endtask

    task automatic test_impulse_r4();
        apply_reset(6'd4);
        impulse_r4("impulse_r4", 1);
        $display("test_impulse_r4 done: %0d/%0d", passes, checks);
    endtask

    task automatic test_rate3_and_clamp();
        int r0, o0, s0;
        apply_reset(6'd3);
        in_data_I = 18'sd131071; in_data_Q = -18'sd131071;
        o0 = out_i.size();
        strobes(60, 2);
        for (int j = 40; j < 60; j++) begin
            checks++; if (out_i[o0+j] !== 41471) $display("FAIL r3_I[%0d]: got %0d expected 41471", j, out_i[o0+j]); else passes++;
            checks++; if (out_q[o0+j] !== -41472) $display("FAIL r3_Q[%0d]: got %0d expected -41472", j, out_q[o0+j]); else passes++;
        end
        apply_reset(6'd0);
        r0 = req_log.size(); s0 = strobe_total;
        strobes(20, 1);
        checks++; if (req_log.size() - r0 != 10) $display("FAIL clamp_lo_count: got %0d expected 10", req_log.size() - r0); else passes++;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_log[r0+k] - s0 !== 2*k + 1) $display("FAIL clamp_lo_pos[%0d]: got %0d expected %0d", k, req_log[r0+k] - s0, 2*k + 1);
            else passes++;
        end
        apply_reset(6'd63);
        r0 = req_log.size(); s0 = strobe_total;
        strobes(81, 1);
        checks++; if (req_log.size() - r0 != 3) $display("FAIL clamp_hi_count: got %0d expected 3", req_log.size() - r0); else passes++;
        checks++; if (req_log[r0+1] - s0 !== 41) $display("FAIL clamp_hi_pos: got %0d expected 41", req_log[r0+1] - s0); else passes++;
        $display("test_rate3_and_clamp done: %0d/%0d", passes, checks);
    endtask

    task automatic test_underrun();
        int r0, o0, s0, min_i;
        apply_reset(6'd8);
        in_data_I = 18'sd2000; in_data_Q = -18'sd2000;
        r0 = req_log.size(); o0 = out_i.size(); s0 = strobe_total;
        checks++; if (underrun !== 1'b0) $display("FAIL ur_initial: got %b expected 0", underrun); else passes++;
        strobes(48, 2);
        checks++; if (out_i[o0+47] !== 2000) $display("FAIL ur_before: got %0d expected 2000", out_i[o0+47]); else passes++;
        in_valid = 1'b0;
        strobes(1, 2);
        in_valid = 1'b1;
        checks++; if (underrun !== 1'b1) $display("FAIL ur_set: got %b expected 1", underrun); else passes++;
        checks++; if (req_log[r0+6] - s0 !== 49) $display("FAIL ur_req_pos: got %0d expected 49", req_log[r0+6] - s0); else passes++;
        strobes(80, 2);
        checks++; if (underrun !== 1'b1) $display("FAIL ur_sticky: got %b expected 1", underrun); else passes++;
        min_i = 2000;
        for (int j = 49; j < 129; j++) if (out_i[o0+j] < min_i) min_i = out_i[o0+j];
        checks++; if (!(min_i < 2000)) $display("FAIL ur_dip: min got %0d expected below 2000", min_i); else passes++;
        for (int j = 119; j < 129; j++) begin
            checks++; if (out_i[o0+j] !== 2000) $display("FAIL ur_recover[%0d]: got %0d expected 2000", j, out_i[o0+j]); else passes++;
        end
        $display("test_underrun done: %0d/%0d", passes, checks);
    endtask

    task automatic test_rate_change();
        int r0, o0, s0;
        apply_reset(6'd8);
        in_data_I = 18'sd1500; in_data_Q = -18'sd1500;
        strobes(43, 4);
        rate = 6'd16;
        sample_strobe = 1'b1;
        #1;
        checks++; if (in_req !== 1'b0) $display("FAIL rc_req_ignored: got %b expected 0", in_req); else passes++;
        tick();
        sample_strobe = 1'b0;
        checks++; if (out_strobe !== 1'b0) $display("FAIL rc_out_strobe: got %b expected 0", out_strobe); else passes++;
        checks++; if (out_data_I !== 18'sd0) $display("FAIL rc_cleared: got %0d expected 0", out_data_I); else passes++;
        r0 = req_log.size(); o0 = out_i.size(); s0 = strobe_total;
        strobes(100, 2);
        checks++; if (req_log.size() - r0 != 7) $display("FAIL rc_req_count: got %0d expected 7", req_log.size() - r0); else passes++;
        checks++; if (req_log[r0] - s0 !== 1) $display("FAIL rc_first_req: got %0d expected 1", req_log[r0] - s0); else passes++;
        checks++; if (req_log[r0+1] - s0 !== 17) $display("FAIL rc_second_req: got %0d expected 17", req_log[r0+1] - s0); else passes++;
        for (int j = 85; j < 100; j++) begin
            checks++; if (out_i[o0+j] !== 1500) $display("FAIL rc_I[%0d]: got %0d expected 1500", j, out_i[o0+j]); else passes++;
            checks++; if (out_q[o0+j] !== -1500) $display("FAIL rc_Q[%0d]: got %0d expected -1500", j, out_q[o0+j]); else passes++;
        end
        $display("test_rate_change done: %0d/%0d", passes, checks);
    endtask

    task automatic test_reset_midburst();
        apply_reset(6'd4);
        in_data_I = 18'sd2500; in_data_Q = -18'sd2500;
        strobes(10, 3);
        reset = 1'b1;
        tick();
        checks++; if (out_data_I !== 18'sd0) $display("FAIL mid_reset_I: got %0d expected 0", out_data_I); else passes++;
        checks++; if (out_data_Q !== 18'sd0) $display("FAIL mid_reset_Q: got %0d expected 0", out_data_Q); else passes++;
        checks++; if (out_strobe !== 1'b0) $display("FAIL mid_reset_strobe: got %b expected 0", out_strobe); else passes++;
        reset = 1'b0;
        impulse_r4("mid_reset", 3);
        $display("test_reset_midburst done: %0d/%0d", passes, checks);
    endtask

    initial begin
        build_coef();
        test_reset();
        test_constant_r8();
        test_impulse_r4();
        test_rate3_and_clamp();
        test_underrun();
        test_rate_change();
        test_reset_midburst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
